mux_packer: RTL and testbench
=============================

MUX_PACKER -- requirements
Module: mux_packer

Interface
REQ-001 Parameter MST_DWIDTH, default 32, width of the packed output word.
REQ-002 Parameter SYS_DWIDTH, default 8, width of each decryptor byte; MST_DWIDTH SHALL be 4*SYS_DWIDTH.
REQ-003 clk_sys  input  1  system clock; the only clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 select  input  2  source channel: 0 Caesar, 1 Scytale, 2 ZigZag, 3 none.
REQ-006 data0_i / valid0_i  input  SYS_DWIDTH / 1  Caesar decryptor byte and qualifier.
REQ-007 data1_i / valid1_i  input  SYS_DWIDTH / 1  Scytale decryptor byte and qualifier.
REQ-008 data2_i / valid2_i  input  SYS_DWIDTH / 1  ZigZag decryptor byte and qualifier.
REQ-009 ready_i  input  1  downstream accepts data_o when high with valid_o.
REQ-010 data_o  output  MST_DWIDTH  packed decrypted word, registered.
REQ-011 valid_o  output  1  data_o holds an unconsumed word, registered.
REQ-012 overflow_o  output  1  one-cycle pulse when a selected byte is dropped, registered.

Function
REQ-013 A byte SHALL be accepted on an edge when the valid input of the channel named by select is high; the valid inputs and data of unselected channels, and all channels when select=3, SHALL be ignored.
REQ-014 Byte k (k=0..3) of a word SHALL be placed at data bits [8k+7:8k]; the first accepted byte is the LSB, matching demux packet order.
REQ-015 Assembly FSM states: IDLE (0 bytes), COLLECT (1-3 bytes, counter 2 bits), FULL (4 bytes held, output register occupied).
REQ-016 IDLE -> COLLECT on an accepted byte; COLLECT increments the counter per accepted byte; the 4th byte completes the word.
REQ-017 On the completing edge, if valid_o is low or valid_o&&ready_i is high that edge, the word SHALL load data_o and valid_o SHALL be high after that edge (latency: 1 edge from 4th byte to valid_o); FSM -> IDLE.
REQ-018 Otherwise the FSM SHALL enter FULL holding the word; on the first edge with valid_o&&ready_i it SHALL load data_o, keep valid_o high, and return to IDLE.
REQ-019 valid_o SHALL drop after an edge with valid_o&&ready_i only when no new word loads on that edge; data_o SHALL not change while valid_o is high and ready_i is low.
REQ-020 In FULL, a selected byte SHALL be dropped and overflow_o SHALL be high for exactly the following cycle; the held word is unaffected.
REQ-021 A change of select relative to the previous cycle SHALL discard a partial word (COLLECT -> IDLE, counter 0); a byte from the new channel on the same edge SHALL be accepted as byte 0; a held FULL word and data_o SHALL be kept.
REQ-022 Byte gaps (valid low cycles) between bytes of one word SHALL be allowed without limit.
REQ-023 Bytes with value 0 SHALL be accepted as data.

Reset
REQ-024 While rst is high: data_o=0, valid_o=0, overflow_o=0, FSM=IDLE, counter=0, assembly buffer=0, previous-select register=0; effective immediately, not waiting for clk_sys.
REQ-025 Reset mid-word or in FULL SHALL discard all held data; the first edge after rst falls SHALL accept a byte normally.

Structure
REQ-026 A shared package decrypt_pkg SHALL hold MST_DWIDTH/SYS_DWIDTH defaults, select codes SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2, SEL_NONE=3, and the FSM state type; demux SHALL use the same select codes.
REQ-027 The block SHALL be a single module with no sub-module; channel selection is a combinational pre-stage feeding the FSM.

Verification
REQ-028 select=0, ready_i=1, valid0_i on 4 consecutive edges with 0x11,0x22,0x33,0x44 -> data_o=0x44332211, valid_o high one cycle after 4th byte, for 1 cycle.
REQ-029 select=1, bytes on valid0_i and valid2_i only, then 0xDE,0xAD,0xBE,0xEF on valid1_i -> only 0xEFBEADDE produced.
REQ-030 ready_i=0, two words 0x04030201 then 0x08070605, then a 9th byte 0xFF -> data_o holds 0x04030201, overflow_o pulses once; ready_i=1 for 2 cycles -> 0x04030201 then 0x08070605 back to back, valid_o then low.
REQ-031 select=2, bytes 0xAA,0xBB, switch select to 0, bytes 0x01..0x04 on valid0_i -> single word 0x04030201, 0xAA/0xBB never appear.
REQ-032 Assert rst asynchronously after 3 bytes and while valid_o high -> data_o=0, valid_o=0 before next edge; next 4 bytes 0x0A..0x0D -> 0x0D0C0B0A.
REQ-033 Bytes 0x00 x4 with 2-cycle gaps, select=0 -> data_o=0x00000000 with valid_o high.

Source files
------------

// File: rtl/decrypt_pkg.sv
// Shared definitions for the decryptor output path: data widths, channel
// select codes (also used by the demux) and the packer FSM state type.
package decrypt_pkg;

  localparam int unsigned MST_DWIDTH_DEF = 32;
  localparam int unsigned SYS_DWIDTH_DEF = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_NONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } pack_state_e;

endpackage

// File: rtl/mux_packer.sv
// Selects one decryptor byte stream and packs four bytes (first byte = LSB)
// into a word with a valid/ready output and a one-word holding buffer.
module mux_packer
  import decrypt_pkg::*;
#(
  parameter int unsigned MST_DWIDTH = MST_DWIDTH_DEF,
  parameter int unsigned SYS_DWIDTH = SYS_DWIDTH_DEF
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic                  valid0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic                  valid1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid2_i,
  input  logic                  ready_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overflow_o
);

  pack_state_e           state;
  logic [1:0]            cnt;
  logic [1:0]            prev_sel;
  logic [MST_DWIDTH-1:0] word_buf;

  logic                  byte_valid_c;
  logic [SYS_DWIDTH-1:0] byte_data_c;
  logic                  sel_changed_c;
  logic                  pop_c;
  logic [1:0]            eff_cnt_c;
  logic [MST_DWIDTH-1:0] merged_c;

  // Channel pre-stage: only the selected decryptor can present a byte.
  always_comb begin
    byte_valid_c = 1'b0;
    byte_data_c  = '0;
    case (select)
      SEL_CAESAR: begin
        byte_valid_c = valid0_i;
        byte_data_c  = data0_i;
      end
      SEL_SCYTALE: begin
        byte_valid_c = valid1_i;
        byte_data_c  = data1_i;
      end
      SEL_ZIGZAG: begin
        byte_valid_c = valid2_i;
        byte_data_c  = data2_i;
      end
      SEL_NONE: begin
        byte_valid_c = 1'b0;
        byte_data_c  = '0;
      end
      default: begin
        byte_valid_c = 1'b0;
        byte_data_c  = '0;
      end
    endcase
  end

  // A select change restarts the word, so the incoming byte lands at slot 0.
  always_comb begin
    sel_changed_c = (select != prev_sel);
    pop_c         = valid_o & ready_i;
    eff_cnt_c     = sel_changed_c ? 2'd0 : cnt;
    merged_c      = sel_changed_c ? '0 : word_buf;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (eff_cnt_c == 2'(k)) begin
        merged_c[k*SYS_DWIDTH +: SYS_DWIDTH] = byte_data_c;
      end
    end
  end

  // Assembly FSM with registered output word, valid and overflow pulse.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      prev_sel   <= 2'd0;
      word_buf   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      prev_sel   <= select;
      overflow_o <= 1'b0;
      if (pop_c) begin
        valid_o <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (byte_valid_c) begin
            if (eff_cnt_c == 2'd3) begin
              cnt <= 2'd0;
              if (!valid_o || pop_c) begin
                // Output slot free this edge: publish the word directly.
                data_o   <= merged_c;
                valid_o  <= 1'b1;
                word_buf <= '0;
                state    <= ST_IDLE;
              end else begin
                word_buf <= merged_c;
                state    <= ST_FULL;
              end
            end else begin
              word_buf <= merged_c;
              cnt      <= eff_cnt_c + 2'd1;
              state    <= ST_COLLECT;
            end
          end else if (sel_changed_c) begin
            word_buf <= '0;
            cnt      <= 2'd0;
            state    <= ST_IDLE;
          end
        end
        ST_FULL: begin
          // Held word survives select changes; new bytes have nowhere to go.
          if (byte_valid_c) begin
            overflow_o <= 1'b1;
          end
          if (pop_c) begin
            data_o   <= word_buf;
            valid_o  <= 1'b1;
            word_buf <= '0;
            cnt      <= 2'd0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_packer.sv
// Directed self-checking bench for mux_packer.
module tb_mux_packer;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic [7:0]  data0_i, data1_i, data2_i;
  logic        valid0_i, valid1_i, valid2_i;
  logic        ready_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        overflow_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mux_packer #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .select     (select),
    .data0_i    (data0_i),
    .valid0_i   (valid0_i),
    .data1_i    (data1_i),
    .valid1_i   (valid1_i),
    .data2_i    (data2_i),
    .valid2_i   (valid2_i),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_bytes();
    valid0_i = 1'b0;
    valid1_i = 1'b0;
    valid2_i = 1'b0;
    data0_i  = 8'h00;
    data1_i  = 8'h00;
    data2_i  = 8'h00;
  endtask

  task automatic set_byte(input int ch, input logic [7:0] d);
    clear_bytes();
    case (ch)
      0: begin valid0_i = 1'b1; data0_i = d; end
      1: begin valid1_i = 1'b1; data1_i = d; end
      default: begin valid2_i = 1'b1; data2_i = d; end
    endcase
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    select = 2'd0;
    ready_i = 1'b0;
    clear_bytes();
    tick();
    tick();
    tests_run++;
    if (data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected %h", data_o, 32'h0);
    end
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
    tests_run++;
    if (overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_overflow: got %b expected 0", overflow_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    select  = 2'd0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_byte(0, b[i]);
      tick();
      if (i == 2) begin
        tests_run++;
        if (valid_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_early_valid: got %b expected 0", valid_o);
        end
      end
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h44332211) begin
      tests_failed++;
      $display("FAIL basic_word: got valid=%b data=%h expected valid=1 data=44332211", valid_o, data_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_valid_drop: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_channel_filter();
    logic [7:0] b [4];
    b[0] = 8'hDE; b[1] = 8'hAD; b[2] = 8'hBE; b[3] = 8'hEF;
    select  = 2'd1;
    ready_i = 1'b1;
    set_byte(0, 8'h55); tick();
    set_byte(2, 8'h66); tick();
    set_byte(0, 8'h77); tick();
    set_byte(2, 8'h88); tick();
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL filter_foreign_bytes: got valid=%b data=%h expected valid=0", valid_o, data_o);
    end
    for (int i = 0; i < 4; i++) begin
      set_byte(1, b[i]);
      tick();
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'hEFBEADDE) begin
      tests_failed++;
      $display("FAIL filter_word: got valid=%b data=%h expected valid=1 data=efbeadde", valid_o, data_o);
    end
    tick();
  endtask

  task automatic test_overflow();
    select  = 2'd0;
    ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set_byte(0, 8'(i));
      tick();
      if (i == 4) begin
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'h04030201) begin
          tests_failed++;
          $display("FAIL ovf_first_word: got valid=%b data=%h expected valid=1 data=04030201", valid_o, data_o);
        end
      end
    end
    tests_run++;
    if (data_o !== 32'h04030201 || overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_held: got data=%h ovf=%b expected data=04030201 ovf=0", data_o, overflow_o);
    end
    set_byte(0, 8'hFF);
    tick();
    clear_bytes();
    tests_run++;
    if (overflow_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_pulse: got %b expected 1", overflow_o);
    end
    tick();
    tests_run++;
    if (overflow_o !== 1'b0 || data_o !== 32'h04030201) begin
      tests_failed++;
      $display("FAIL ovf_pulse_end: got ovf=%b data=%h expected ovf=0 data=04030201", overflow_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h08070605) begin
      tests_failed++;
      $display("FAIL ovf_second_word: got valid=%b data=%h expected valid=1 data=08070605", valid_o, data_o);
    end
    tick();
    ready_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_drain: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_select_switch();
    ready_i = 1'b1;
    select  = 2'd2;
    set_byte(2, 8'hAA); tick();
    set_byte(2, 8'hBB); tick();
    select = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      set_byte(0, 8'(i));
      tick();
      if (i == 2) begin
        tests_run++;
        if (valid_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL switch_stale_word: got valid=%b data=%h expected valid=0", valid_o, data_o);
        end
      end
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h04030201) begin
      tests_failed++;
      $display("FAIL switch_word: got valid=%b data=%h expected valid=1 data=04030201", valid_o, data_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    select  = 2'd0;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_byte(0, 8'(8'h10 + i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_byte(0, 8'(8'h21 + i));
      tick();
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h13121110) begin
      tests_failed++;
      $display("FAIL areset_pre: got valid=%b data=%h expected valid=1 data=13121110", valid_o, data_o);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got valid=%b data=%h expected valid=0 data=00000000", valid_o, data_o);
    end
    #1 rst = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_byte(0, 8'(8'h0A + i));
      tick();
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h0D0C0B0A) begin
      tests_failed++;
      $display("FAIL areset_after: got valid=%b data=%h expected valid=1 data=0d0c0b0a", valid_o, data_o);
    end
    tick();
  endtask

  task automatic test_zero_gaps();
    select  = 2'd0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_byte(0, 8'h00);
      tick();
      clear_bytes();
      if (i == 3) begin
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'h0) begin
          tests_failed++;
          $display("FAIL zero_word: got valid=%b data=%h expected valid=1 data=00000000", valid_o, data_o);
        end
      end else begin
        tick();
        tick();
        tests_run++;
        if (valid_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL zero_gap_%0d: got valid=%b expected 0", i, valid_o);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    select  = 2'd0;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_byte(0, 8'(8'hA0 + i));
      tick();
      if (i == 3) begin
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'hA3A2A1A0) begin
          tests_failed++;
          $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=a3a2a1a0", valid_o, data_o);
        end
      end
      if (i == 4) begin
        tests_run++;
        if (valid_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_gap: got %b expected 0", valid_o);
        end
      end
    end
    clear_bytes();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'hA7A6A5A4 || overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: got valid=%b data=%h ovf=%b expected valid=1 data=a7a6a5a4 ovf=0", valid_o, data_o, overflow_o);
    end
    tick();
  endtask

  task automatic test_full_keeps_on_switch();
    select  = 2'd0;
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_byte(0, 8'(8'hC0 + i));
      tick();
    end
    select = 2'd1;
    set_byte(1, 8'h99);
    tick();
    clear_bytes();
    tests_run++;
    if (overflow_o !== 1'b1 || data_o !== 32'hC3C2C1C0) begin
      tests_failed++;
      $display("FAIL fullsw_drop: got ovf=%b data=%h expected ovf=1 data=c3c2c1c0", overflow_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'hC7C6C5C4) begin
      tests_failed++;
      $display("FAIL fullsw_held: got valid=%b data=%h expected valid=1 data=c7c6c5c4", valid_o, data_o);
    end
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_channel_filter();
    test_overflow();
    test_select_switch();
    test_async_reset();
    test_zero_gaps();
    test_back_to_back();
    test_full_keeps_on_switch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
